// File: rtl/awg_seq_pkg.sv
// Shared types and constants for the waveform segment sequencer.
package awg_seq_pkg;

  localparam int unsigned PHASE_W_DEF = 32;
  localparam int unsigned DUR_W_DEF   = 24;
  localparam int unsigned WAVE_W      = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  typedef enum logic [WAVE_W-1:0] {
    SAW    = 3'd0,
    RAMP   = 3'd1,
    SQUARE = 3'd2,
    TRI    = 3'd3,
    SIN    = 3'd4,
    NOISE  = 3'd5
  } wave_t;

  // One program step: waveform, starting increment, per-cycle sweep, length.
  typedef struct packed {
    logic [WAVE_W-1:0]      wave;
    logic [PHASE_W_DEF-1:0] adder;
    logic [PHASE_W_DEF-1:0] step;
    logic [DUR_W_DEF-1:0]   dur;
  } seg_t;

endpackage

// File: rtl/waveform_sequencer_seq_table.sv
// Segment register file: synchronous write, asynchronous read.
module seq_table
  import awg_seq_pkg::*;
#(
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  seg_t              wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output seg_t              rd_data
);

  seg_t mem [DEPTH];

  // Table storage; cleared by reset, written from the config port.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/waveform_sequencer.sv
// Plays a table of waveform segments into the phase-accumulator generator.
module waveform_sequencer
  import awg_seq_pkg::*;
#(
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned ADDR_W  = 3,
  parameter int unsigned DUR_W   = DUR_W_DEF,
  parameter int unsigned PHASE_W = PHASE_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cfg_we,
  input  logic [ADDR_W-1:0]  cfg_addr,
  input  logic [2:0]         cfg_wave,
  input  logic [PHASE_W-1:0] cfg_adder,
  input  logic [PHASE_W-1:0] cfg_step,
  input  logic [DUR_W-1:0]   cfg_dur,
  input  logic [ADDR_W-1:0]  last_index,
  input  logic [7:0]         loop_count,
  input  logic               start,
  input  logic               stop,
  input  logic               pause,
  output logic [2:0]         signal_number,
  output logic [PHASE_W-1:0] adder,
  output logic [ADDR_W-1:0]  seg_index,
  output logic               busy,
  output logic               done
);

  state_t             state;
  seg_t               wr_data;
  seg_t               nxt;
  logic [ADDR_W-1:0]  next_idx;
  logic [ADDR_W-1:0]  last_q;
  logic [7:0]         loop_q;
  logic [7:0]         pass_cnt;
  logic [DUR_W-1:0]   dur_cnt;
  logic [DUR_W-1:0]   dur_last;
  logic [DUR_W-1:0]   nxt_dur_last;
  logic [PHASE_W-1:0] acc;
  logic [PHASE_W-1:0] step_q;
  logic [PHASE_W-1:0] acc_next;
  logic               seg_end;
  logic               prog_end;

  assign wr_data = '{wave: cfg_wave, adder: cfg_adder, step: cfg_step, dur: cfg_dur};

  seq_table #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_table (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (cfg_we),
    .wr_addr (cfg_addr),
    .wr_data (wr_data),
    .rd_addr (next_idx),
    .rd_data (nxt)
  );

  // Next entry to load, end-of-segment and end-of-program decode.
  always_comb begin
    next_idx     = '0;
    if (state != IDLE && seg_index != last_q) begin
      next_idx = ADDR_W'(seg_index + ADDR_W'(1));
    end
    nxt_dur_last = (nxt.dur == '0) ? '0 : DUR_W'(nxt.dur - DUR_W'(1));
    seg_end      = (dur_cnt == dur_last);
    prog_end     = (seg_index == last_q) && (loop_q != 8'd0) &&
                   ((9'({1'b0, pass_cnt}) + 9'd1) >= 9'({1'b0, loop_q}));
    acc_next     = PHASE_W'(acc + step_q);
  end

  // Sequencer state machine with registered generator outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      signal_number <= '0;
      adder         <= '0;
      seg_index     <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      acc           <= '0;
      step_q        <= '0;
      dur_cnt       <= '0;
      dur_last      <= '0;
      pass_cnt      <= '0;
      last_q        <= '0;
      loop_q        <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start && !stop) begin
            state         <= RUN;
            busy          <= 1'b1;
            last_q        <= last_index;
            loop_q        <= loop_count;
            pass_cnt      <= '0;
            seg_index     <= next_idx;
            signal_number <= nxt.wave;
            acc           <= nxt.adder;
            adder         <= nxt.adder;
            step_q        <= nxt.step;
            dur_cnt       <= '0;
            dur_last      <= nxt_dur_last;
          end
        end
        RUN: begin
          if (stop || (seg_end && prog_end)) begin
            state         <= IDLE;
            busy          <= 1'b0;
            adder         <= '0;
            signal_number <= '0;
            seg_index     <= '0;
            done          <= !stop;
          end else begin
            if (pause) begin
              state <= PAUSE;
            end
            if (seg_end) begin
              if (seg_index == last_q) begin
                pass_cnt <= 8'(pass_cnt + 8'd1);
              end
              seg_index     <= next_idx;
              signal_number <= nxt.wave;
              acc           <= nxt.adder;
              step_q        <= nxt.step;
              dur_cnt       <= '0;
              dur_last      <= nxt_dur_last;
              adder         <= pause ? '0 : nxt.adder;
            end else begin
              dur_cnt <= DUR_W'(dur_cnt + DUR_W'(1));
              acc     <= acc_next;
              adder   <= pause ? '0 : acc_next;
            end
          end
        end
        PAUSE: begin
          if (stop) begin
            state         <= IDLE;
            busy          <= 1'b0;
            adder         <= '0;
            signal_number <= '0;
            seg_index     <= '0;
          end else if (!pause) begin
            state <= RUN;
            adder <= acc;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
